prga_decrypt: RTL and testbench

//  RC4 pseudo-random generation + decrypt stage; runs after S-memory init/KSA-swap completes.

---
 rtl/rc4_pkg.sv | 31 +++
 rtl/prga_decrypt.sv | 171 +++++++++++++++++
 tb/tb_prga_decrypt.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// RC4 shared constants, PRGA/decrypt state encoding and the plaintext character test.
// Imported by prga_decrypt.
package rc4_pkg;

    localparam int S_SIZE = 256;
    localparam int S_AW   = $clog2(S_SIZE);

    localparam logic [7:0] ASCII_SPACE = 8'd32;
    localparam logic [7:0] ASCII_LO    = 8'd97;
    localparam logic [7:0] ASCII_HI    = 8'd122;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_SI,
        ST_LAT_SI,
        ST_RD_SJ,
        ST_LAT_SJ,
        ST_WR_SI,
        ST_WR_SJ,
        ST_RD_F,
        ST_LAT_F,
        ST_WR_OUT,
        ST_DONE
    } prga_state_t;

    // Accepted plaintext alphabet: space or lowercase letters.
    function automatic logic is_msg_char(input logic [7:0] b);
        return (b == ASCII_SPACE) || ((b >= ASCII_LO) && (b <= ASCII_HI));
    endfunction

endpackage

// File: rtl/prga_decrypt.sv
// RC4 PRGA + XOR decrypt: swaps S[i]/S[j], reads keystream S[si+sj], writes ROM^f to RAM.
// Latency: 3*MEM_RD_WAIT+6 cycles per byte; done after MSG_LEN bytes (early abort with PRGA_ASCII_CHECK_EN).
// No backpressure: memories are assumed always ready; start is a level, ignored while busy.
module prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN     = 32,
    parameter int MEM_RD_WAIT = 1,
    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [7:0]    s_addr,
    output logic [7:0]    s_wdata,
    input  logic [7:0]    s_rdata,
    output logic          s_wren,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          ram_wren,
    output logic          msg_valid
);

    localparam int              WW     = (MEM_RD_WAIT > 1) ? $clog2(MEM_RD_WAIT) : 1;
    localparam logic [WW-1:0]   W_LAST = WW'(MEM_RD_WAIT - 1);
    localparam logic [AW-1:0]   K_LAST = AW'(MSG_LEN - 1);

    prga_state_t     state, state_nxt;
    logic [WW-1:0]   wait_cnt;
    logic [S_AW-1:0] i, j;
    logic [AW-1:0]   k;
    logic [7:0]      si, sj, f, enc;
    logic [7:0]      f_idx;
    logic [7:0]      plain;
    logic            rd_state;
    logic            wait_done;
    logic            abort;

    assign f_idx     = si + sj;
    assign plain     = f ^ enc;
    assign rd_state  = (state == ST_RD_SI) || (state == ST_RD_SJ) || (state == ST_RD_F);
    assign wait_done = (wait_cnt == W_LAST);

`ifdef PRGA_ASCII_CHECK_EN
    assign abort = !is_msg_char(plain);
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_RD_SI;
            ST_RD_SI:  if (wait_done) state_nxt = ST_LAT_SI;
            ST_LAT_SI: state_nxt = ST_RD_SJ;
            ST_RD_SJ:  if (wait_done) state_nxt = ST_LAT_SJ;
            ST_LAT_SJ: state_nxt = ST_WR_SI;
            ST_WR_SI:  state_nxt = ST_WR_SJ;
            ST_WR_SJ:  state_nxt = ST_RD_F;
            ST_RD_F:   if (wait_done) state_nxt = ST_LAT_F;
            ST_LAT_F:  state_nxt = ST_WR_OUT;
            ST_WR_OUT: state_nxt = ((k == K_LAST) || abort) ? ST_DONE : ST_RD_SI;
            ST_DONE:   if (!start) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // RD_* states are only entered from non-RD states, so staying put is the only count case.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (rd_state && (state_nxt == state)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i         <= '0;
            j         <= '0;
            k         <= '0;
            si        <= '0;
            sj        <= '0;
            f         <= '0;
            enc       <= '0;
            msg_valid <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        i         <= S_AW'(1);
                        j         <= '0;
                        k         <= '0;
                        msg_valid <= 1'b1;
                    end
                end
                ST_LAT_SI: begin
                    si <= s_rdata;
                    j  <= j + s_rdata;
                end
                ST_LAT_SJ: begin
                    sj <= s_rdata;
                end
                ST_LAT_F: begin
                    f   <= s_rdata;
                    enc <= rom_rdata;
                end
                ST_WR_OUT: begin
                    if (abort) begin
                        msg_valid <= 1'b0;
                    end else if (k != K_LAST) begin
                        k <= k + 1'b1;
                        i <= i + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Addresses are held through the latch cycle so read data stays stable while captured.
    always_comb begin
        s_addr    = '0;
        s_wdata   = '0;
        s_wren    = 1'b0;
        rom_addr  = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wren  = 1'b0;
        done      = 1'b0;
        case (state)
            ST_RD_SI, ST_LAT_SI: s_addr = i;
            ST_RD_SJ, ST_LAT_SJ: s_addr = j;
            ST_WR_SI: begin
                s_addr  = i;
                s_wdata = sj;
                s_wren  = 1'b1;
            end
            ST_WR_SJ: begin
                s_addr  = j;
                s_wdata = si;
                s_wren  = 1'b1;
            end
            ST_RD_F, ST_LAT_F: begin
                s_addr   = f_idx;
                rom_addr = k;
            end
            ST_WR_OUT: begin
                ram_addr  = k;
                ram_wdata = plain;
                ram_wren  = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prga_decrypt.sv
// Directed bench for prga_decrypt: W=1 and W=2 instances, behavioural S/ROM/RAM, RC4 reference model.
`timescale 1ns/1ps
module tb_prga_decrypt;

    localparam int MSG_LEN = 32;
    localparam int AW      = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic load  = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    always #5 clk = ~clk;

    logic          done_a, s_wren_a, ram_wren_a, msg_valid_a;
    logic [7:0]    s_addr_a, s_wdata_a, s_rdata_a, rom_rdata_a, ram_wdata_a;
    logic [AW-1:0] rom_addr_a, ram_addr_a;
    logic          done_b, s_wren_b, ram_wren_b, msg_valid_b;
    logic [7:0]    s_addr_b, s_wdata_b, s_rdata_b, rom_rdata_b, ram_wdata_b;
    logic [AW-1:0] rom_addr_b, ram_addr_b;

    prga_decrypt #(.MSG_LEN(MSG_LEN), .MEM_RD_WAIT(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .done(done_a),
        .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_rdata(s_rdata_a), .s_wren(s_wren_a),
        .rom_addr(rom_addr_a), .rom_rdata(rom_rdata_a),
        .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_wren(ram_wren_a),
        .msg_valid(msg_valid_a)
    );

    prga_decrypt #(.MSG_LEN(MSG_LEN), .MEM_RD_WAIT(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .done(done_b),
        .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_rdata(s_rdata_b), .s_wren(s_wren_b),
        .rom_addr(rom_addr_b), .rom_rdata(rom_rdata_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_wren(ram_wren_b),
        .msg_valid(msg_valid_b)
    );

    logic [7:0] s_init [256];
    logic [7:0] rom    [MSG_LEN];
    logic [7:0] s_mem_a [256];
    logic [7:0] s_mem_b [256];
    logic [7:0] ram_a  [MSG_LEN];
    logic [7:0] ram_b  [MSG_LEN];

    // Synchronous-read memories, one cycle of q latency; load copies s_init and fills RAM with 0xEE.
    always @(posedge clk) begin
        if (load) begin
            for (int x = 0; x < 256; x++) begin
                s_mem_a[x] <= s_init[x];
                s_mem_b[x] <= s_init[x];
            end
            for (int x = 0; x < MSG_LEN; x++) begin
                ram_a[x] <= 8'hEE;
                ram_b[x] <= 8'hEE;
            end
        end else begin
            if (s_wren_a)   s_mem_a[s_addr_a]  <= s_wdata_a;
            if (s_wren_b)   s_mem_b[s_addr_b]  <= s_wdata_b;
            if (ram_wren_a) ram_a[ram_addr_a]  <= ram_wdata_a;
            if (ram_wren_b) ram_b[ram_addr_b]  <= ram_wdata_b;
        end
        s_rdata_a   <= s_mem_a[s_addr_a];
        s_rdata_b   <= s_mem_b[s_addr_b];
        rom_rdata_a <= rom[rom_addr_a];
        rom_rdata_b <= rom[rom_addr_b];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [7:0] m_s [256];
    logic [7:0] ks  [MSG_LEN];
    logic [7:0] exp_ram [MSG_LEN];
    int         m_nb;
    bit         m_valid;
    string      plain_txt = "attack at dawn the quick fox jum";

    function automatic bit pt_ok(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7a);
    endfunction

    task automatic build_identity();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    endtask

    task automatic build_ksa();
        logic [7:0] key [3];
        logic [7:0] jj, t;
        key[0] = 8'h00; key[1] = 8'h00; key[2] = 8'hFF;
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        jj = 8'h00;
        for (int x = 0; x < 256; x++) begin
            jj = jj + s_init[x] + key[x % 3];
            t = s_init[x]; s_init[x] = s_init[jj]; s_init[jj] = t;
        end
    endtask

    // Textbook RC4 PRGA for n bytes on m_s, starting from i=j=0 with pre-increment.
    task automatic gen_ks(input int n);
        logic [7:0] ii, jj, t, idx;
        ii = 8'h00; jj = 8'h00;
        for (int x = 0; x < n; x++) begin
            ii = ii + 8'h01;
            jj = jj + m_s[ii];
            t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
            idx = m_s[ii] + m_s[jj];
            ks[x] = m_s[idx];
        end
    endtask

    task automatic build_rom(input int kind);
        logic [7:0] p;
        for (int x = 0; x < 256; x++) m_s[x] = s_init[x];
        gen_ks(MSG_LEN);
        for (int x = 0; x < MSG_LEN; x++) begin
            p = plain_txt[x];
            if (kind == 2 && x == 3) p = 8'h41;
            rom[x] = (kind == 0) ? 8'h00 : (p ^ ks[x]);
        end
    endtask

    // Fills exp_ram[0..m_nb-1]; the caller presets the untouched entries.
    task automatic compute_expected();
        logic [7:0] p;
        for (int x = 0; x < 256; x++) m_s[x] = s_init[x];
        gen_ks(MSG_LEN);
        m_nb = 0; m_valid = 1'b1;
        for (int x = 0; x < MSG_LEN && m_nb == x; x++) begin
            p = rom[x] ^ ks[x];
            exp_ram[x] = p;
`ifdef PRGA_ASCII_CHECK_EN
            if (!pt_ok(p)) m_valid = 1'b0;
`endif
            if (m_valid) m_nb = x + 1;
            else         m_nb = x + 1 + MSG_LEN;
        end
        if (m_nb > MSG_LEN) m_nb = m_nb - MSG_LEN;
        for (int x = 0; x < 256; x++) m_s[x] = s_init[x];
        gen_ks(m_nb);
    endtask

    task automatic do_load();
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic do_run(input int sel, input bit hold, output int edges);
        bit seen;
        seen = 1'b0; edges = -1;
        @(negedge clk);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4000 && !seen; c++) begin
            @(posedge clk); #1;
            if ((sel == 0) ? done_a : done_b) begin
                seen = 1'b1; edges = c;
            end
        end
        if (!hold) begin
            @(negedge clk); start_a = 1'b0; start_b = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag, input int sel);
        int bad;
        for (int x = 0; x < MSG_LEN; x++)
            chk($sformatf("%s_ram%0d", tag, x), (sel == 0) ? ram_a[x] : ram_b[x], exp_ram[x]);
        bad = 0;
        for (int x = 0; x < 256; x++)
            if (((sel == 0) ? s_mem_a[x] : s_mem_b[x]) !== m_s[x]) bad++;
        chk({tag, "_s_mismatches"}, bad, 0);
        chk({tag, "_msg_valid"}, (sel == 0) ? msg_valid_a : msg_valid_b, m_valid);
    endtask

    typedef struct {
        string name;
        int    sel;        // 0: MEM_RD_WAIT=1, 1: MEM_RD_WAIT=2
        int    s_kind;     // 0: identity, 1: KSA key 0000FF
        int    rom_kind;   // 0: zeros, 1: plaintext, 2: plaintext with 'A' at byte 3
        int    exp_edges;
        bit    exp_valid;
    } vec_t;

    vec_t tbl [4];
    int   edges;
    int   held;

    initial begin
`ifdef PRGA_ASCII_CHECK_EN
        tbl[0] = '{"ident", 0, 0, 0, 9,   1'b0};
        tbl[3] = '{"badch", 0, 1, 2, 36,  1'b0};
`else
        tbl[0] = '{"ident", 0, 0, 0, 288, 1'b1};
        tbl[3] = '{"badch", 0, 1, 2, 288, 1'b1};
`endif
        tbl[1] = '{"ksa_w1", 0, 1, 1, 288, 1'b1};
        tbl[2] = '{"ksa_w2", 1, 1, 1, 384, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_done", done_a, 1'b0);
        chk("rst_s_wren", s_wren_a, 1'b0);
        chk("rst_ram_wren", ram_wren_a, 1'b0);
        chk("rst_s_addr", s_addr_a, 8'h00);
        chk("rst_msg_valid", msg_valid_a, 1'b1);
        reset = 1'b0;

        for (int t = 0; t < 4; t++) begin
            if (tbl[t].s_kind == 0) build_identity(); else build_ksa();
            build_rom(tbl[t].rom_kind);
            for (int x = 0; x < MSG_LEN; x++) exp_ram[x] = 8'hEE;
            compute_expected();
            do_load();
            do_run(tbl[t].sel, 1'b0, edges);
            chk({tbl[t].name, "_done_edge"}, edges, tbl[t].exp_edges);
            chk({tbl[t].name, "_valid_hand"}, (tbl[t].sel == 0) ? msg_valid_a : msg_valid_b,
                tbl[t].exp_valid);
            check_result(tbl[t].name, tbl[t].sel);
            if (t == 0) begin
                chk("ident_ram0_hand", ram_a[0], 8'h02);
`ifndef PRGA_ASCII_CHECK_EN
                chk("ident_ram1_hand", ram_a[1], 8'h05);
`endif
            end
        end

        // Reset while byte 5 is in its WR_SI cycle, then a clean rerun.
        build_ksa();
        build_rom(1);
        do_load();
        @(negedge clk); start_a = 1'b1;
        @(posedge clk);
        repeat (49) @(posedge clk);
        #1;
        chk("rst_mid_wren_before", s_wren_a, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_mid_s_wren", s_wren_a, 1'b0);
        chk("rst_mid_ram_wren", ram_wren_a, 1'b0);
        chk("rst_mid_done", done_a, 1'b0);
        @(negedge clk); start_a = 1'b0;
        @(negedge clk); reset = 1'b0;
        for (int x = 0; x < MSG_LEN; x++) exp_ram[x] = 8'hEE;
        compute_expected();
        do_load();
        do_run(0, 1'b0, edges);
        chk("rerun_done_edge", edges, 288);
        check_result("rerun", 0);

        // Hold start after done, drop it one cycle, restart on the permuted S.
        do_load();
        do_run(0, 1'b1, edges);
        chk("hold_done_edge", edges, 288);
        held = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done_a) held++;
        end
        chk("hold_done_stays", held, 4);
        @(negedge clk); start_a = 1'b0;
        @(posedge clk); #1;
        chk("hold_back_to_idle", done_a, 1'b0);
        for (int x = 0; x < 256; x++) s_init[x] = s_mem_a[x];
        for (int x = 0; x < MSG_LEN; x++) exp_ram[x] = ram_a[x];
        compute_expected();
        do_run(0, 1'b0, edges);
        chk("restart_done_edge", edges, m_nb * 9);
        check_result("restart", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
